// File: rtl/key_io.sv
// KEY push-button device for the data bus: synchronises and debounces ~KEY,
// and exposes it through the KDATA and KCTRL registers with an optional interrupt.
module key_io #(
    parameter int                DBITS     = 32,
    parameter logic [DBITS-1:0]  ADDRKDATA = 32'hFFFFF080,
    parameter logic [DBITS-1:0]  ADDRKCTRL = 32'hFFFFF084,
    parameter int                DEBOUNCE  = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       KEY,
    input  logic [DBITS-1:0] memaddr_M,
    input  logic [DBITS-1:0] wmemval_M,
    input  logic             wrmem_M,
    input  logic             rdmem_M,
    output logic             sel,
    output logic [DBITS-1:0] rdata,
    output logic             irq
);

    localparam int            CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [3:0]    r_s1;
    logic [3:0]    r_s2;
    logic [3:0]    r_kstate;
    logic [CW-1:0] r_cnt;
    logic          r_ready;
    logic          r_overrun;
    logic          r_ie;
    logic          r_irq;

    logic w_hit_data;
    logic w_hit_ctrl;
    logic w_consume;
    logic w_wr_ctrl;
    logic w_change;
    logic w_unused;

    assign w_hit_data = (memaddr_M == ADDRKDATA);
    assign w_hit_ctrl = (memaddr_M == ADDRKCTRL);
    assign w_consume  = w_hit_data & rdmem_M;
    assign w_wr_ctrl  = w_hit_ctrl & wrmem_M;
    assign w_change   = (r_s2 != r_kstate) && (r_cnt == CNT_MAX);
    assign w_unused   = ^{wmemval_M[DBITS-1:5], wmemval_M[3:2], wmemval_M[0]};

    assign sel = w_hit_data | w_hit_ctrl;
    assign irq = r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= ~KEY;
            r_s2 <= r_s1;
        end
    end

    // Any sample equal to the accepted state restarts the count; a different
    // non-accepted value mid-count does not, and is what gets committed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kstate <= '0;
            r_cnt    <= '0;
        end else if (r_s2 == r_kstate) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_kstate <= r_s2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_ie      <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_change)
                r_ready <= 1'b1;
            else if (w_consume)
                r_ready <= 1'b0;

            // Setting overrun takes priority over a software clear on the same edge.
            if (w_change && r_ready && !w_consume)
                r_overrun <= 1'b1;
            else if (w_wr_ctrl && !wmemval_M[1])
                r_overrun <= 1'b0;

            if (w_wr_ctrl)
                r_ie <= wmemval_M[4];

            r_irq <= r_ready & r_ie;
        end
    end

    always_comb begin
        rdata = '0;
        if (w_hit_data) begin
            rdata[3:0] = r_kstate;
        end else if (w_hit_ctrl) begin
            rdata[0] = r_ready;
            rdata[1] = r_overrun;
            rdata[4] = r_ie;
        end
    end

endmodule

// File: doc/key_io.md
# key_io

Memory-mapped KEY input device for the pipelined processor's data bus. It sits downstream of the memory stage, beside data memory and the HEX/LEDR registers. It synchronises and debounces the four active-low push-buttons. Through a data register and a control/status register it exposes the debounced state, a change-ready flag, an overrun flag and an interrupt-enable bit. It replaces the raw `{12'b0,~KEY}` bus decode at ADDRKEY.

## Interface

Parameters:

- DBITS, 32, bus data/address width
- ADDRKDATA, 32'hFFFFF080, address of KDATA (read-only key state)
- ADDRKCTRL, 32'hFFFFF084, address of KCTRL (control/status)
- DEBOUNCE, 100000, number of consecutive clk samples a new key value must hold before acceptance; minimum 2

Ports:

- clk, input, 1, processor clock (PLL output)
- reset, input, 1, asynchronous, active-high; clears all state
- KEY, input, 4, raw board buttons, active-low, asynchronous to clk
- memaddr_M, input, DBITS, bus address from memory stage
- wmemval_M, input, DBITS, bus write data
- wrmem_M, input, 1, bus write strobe for this cycle
- rdmem_M, input, 1, bus read strobe for this cycle; marks a consuming read
- sel, output, 1, combinational; memaddr_M equals ADDRKDATA or ADDRKCTRL
- rdata, output, DBITS, combinational read data; 0 when sel=0
- irq, output, 1, registered; KCTRL.ready & KCTRL.ie

## Operation

- **Synchroniser:** two flops (s1, s2) sample ~KEY. Both reset to 4'b0, meaning "released".
- **Debounce, one counter for the 4-bit vector:**
  - `kstate` is the accepted state; `cnt` is a counter of ceil(log2(DEBOUNCE)) bits.
  - When s2 == kstate: cnt <= 0.
  - When s2 != kstate and cnt != DEBOUNCE-1: cnt <= cnt+1.
  - When s2 != kstate and cnt == DEBOUNCE-1: kstate <= s2 and cnt <= 0. This is a **change event**.
  - A bounce back to kstate at any point restarts the count. If s2 changes to a different non-kstate value mid-count, the count is not restarted; the value present at commit is taken.
- **KDATA read** (sel, address ADDRKDATA): rdata = {28'b0, kstate}.
  - A consuming read (rdmem_M=1) clears KCTRL.ready at the next edge.
  - Writes to KDATA are ignored.
- **KCTRL fields:** bit0 ready, bit1 overrun, bit4 ie; other bits read 0.
  - Read: rdata = {27'b0, ie, 2'b0, overrun, ready}. A read has no side effects.
  - Write: ie <= wmemval_M[4].
  - Writing 0 to bit1 clears overrun; writing 1 to bit1 is ignored.
  - Bit0 write is ignored.
- **Change event:** ready <= 1. If ready was already 1 and is not being cleared this cycle by a consuming KDATA read, overrun <= 1.
- **Simultaneous events, same edge:**
  - Change event plus consuming KDATA read: the read returns the old kstate. Afterwards ready = 1, and overrun is unchanged.
  - Change event that sets overrun plus a KCTRL write clearing overrun: set wins, overrun = 1.
  - KCTRL write plus change event: ie takes the written value, ready = 1.
- **Reset asserted mid-debounce** discards the count. After release, a still-held key is accepted as a fresh change event.
- **Reset values:** s1 = s2 = kstate = 0, cnt = 0, ready = overrun = ie = 0, irq = 0. rdata and sel are combinational; rdata is 0 whenever sel = 0.

## Timing

- Edge k is the first clk edge at which s1 captures a new pin value held stable:
  - s2 holds it after edge k+1.
  - kstate and ready update at edge k+1+DEBOUNCE.
  - irq (if ie) asserts at edge k+2+DEBOUNCE, one cycle later, because irq is registered.
- Key-to-visible latency is exactly DEBOUNCE+2 edges for a clean input.
- rdata is valid in the same cycle as memaddr_M, with no wait states. Side effects of the access take effect at that cycle's edge.
- A pulse shorter than DEBOUNCE samples at s2 never reaches kstate.
- cnt never exceeds DEBOUNCE-1.

## Test plan

All scenarios use DEBOUNCE=4.

1. **Reset:** assert reset asynchronously mid-cycle. Require, with no clock edge, kstate=0, rdata at ADDRKCTRL = 0, irq=0.
2. **Clean press:**
   - Drive KEY=4'b1110, first captured at edge k. Require KDATA=1 and ready=1 after edge k+5, and ready=0 before it.
   - Then perform a consuming KDATA read. Require ready=0 at the next edge.
3. **Bounce rejection:** toggle KEY[1] low for 3 cycles, high for 1, low for 3, then high. Require KDATA to stay 0 and ready to stay 0 throughout.
4. **Overrun:**
   - Press key0, then release key0 without reading. Require ready=1 and overrun=1 (KCTRL=32'h3).
   - Write KCTRL=32'h0. Require KCTRL=32'h1, with overrun cleared and ready still set.
5. **Interrupt and simultaneity:**
   - Write KCTRL=32'h10, then press key3. Require irq=1 exactly one edge after ready rises.
   - On the edge where the release commits, issue a consuming KDATA read. Require the read to return 32'h8, with ready=1 and overrun=0 afterwards.
6. **Reset mid-debounce:** hold key2 pressed and assert reset when cnt=2. After release, require KDATA=4 exactly DEBOUNCE+2 edges later.
